// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - PC, imem request/response and decode channels of the fetch stage
interface fetch_stage_if;
   logic [31:0] pc;
   logic        pc_hold;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;

   // fetch stage side
   modport master (
      input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      output pc_hold, imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc_plus4, id_instr
   );

   // PC mux / imem / decode side
   modport slave (
      output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      input  pc_hold, imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc_plus4, id_instr
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: credit-limited imem requests, in-order responses, {pc,instr} FIFO to decode
module fetch_stage #(
   parameter int FIFO_DEPTH      = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input logic          clk,
   input logic          reset,
   fetch_stage_if.master bus
);
   localparam int IW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [IW-1:0] inflight_q, inflight_d;
   logic [IW-1:0] drop_q, drop_d;
   logic [31:0]   aq_q [MAX_OUTSTANDING];
   logic [31:0]   aq_d [MAX_OUTSTANDING];
   logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
   logic [31:0]   fpc_q [FIFO_DEPTH];
   logic [31:0]   fpc_d [FIFO_DEPTH];
   logic [31:0]   finstr_q [FIFO_DEPTH];
   logic [31:0]   finstr_d [FIFO_DEPTH];
   logic [PW-1:0] fwr_q, fwr_d, frd_q, frd_d;
   logic [FW-1:0] fcnt_q, fcnt_d;

   logic        rsp_ok, rsp_drop, rsp_keep;
   logic        id_valid_w, pop, req_valid_w, fire;
   logic [31:0] live;

   // addr queue depth need not be a power of two, so wrap explicitly
   function automatic logic [AW-1:0] aq_next(input logic [AW-1:0] p);
      return (32'(p) == 32'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // handshake decode and credit: a pop this cycle frees a slot, which keeps 1 instr/cycle with a 2-deep FIFO
   always_comb begin
      rsp_ok      = bus.imem_rsp_valid && (inflight_q != '0);
      rsp_drop    = rsp_ok && (drop_q != '0);
      rsp_keep    = rsp_ok && (drop_q == '0);
      id_valid_w  = (fcnt_q != '0) && !bus.flush;
      pop         = id_valid_w && bus.id_ready;
      live        = 32'(inflight_q) - 32'(drop_q) + 32'(fcnt_q) - 32'(pop);
      req_valid_w = reset && !bus.flush
                    && (32'(inflight_q) < 32'(MAX_OUTSTANDING))
                    && (live < 32'(FIFO_DEPTH));
      fire        = req_valid_w && bus.imem_req_ready;
   end

   // outputs: FIFO head presented combinationally, PC held unless a request is taken or a redirect loads
   always_comb begin
      bus.imem_req_valid = req_valid_w;
      bus.imem_req_addr  = {bus.pc[31:2], 2'b00};
      bus.pc_hold        = !reset || (!fire && !bus.flush);
      bus.id_valid       = id_valid_w;
      bus.id_pc          = fpc_q[frd_q];
      bus.id_pc_plus4    = fpc_q[frd_q] + 32'd4;
      bus.id_instr       = finstr_q[frd_q];
   end

   // next state: issue, response retire/drop, decode pop, flush overrides
   always_comb begin
      inflight_d = inflight_q + IW'(fire) - IW'(rsp_ok);
      drop_d     = drop_q - IW'(rsp_drop);
      aq_d       = aq_q;
      aq_wr_d    = aq_wr_q;
      aq_rd_d    = aq_rd_q;
      fpc_d      = fpc_q;
      finstr_d   = finstr_q;
      fwr_d      = fwr_q;
      frd_d      = frd_q;
      fcnt_d     = fcnt_q + FW'(rsp_keep) - FW'(pop);
      if (fire) begin
         aq_d[aq_wr_q] = bus.pc;
         aq_wr_d       = aq_next(aq_wr_q);
      end
      if (rsp_keep) begin
         fpc_d[fwr_q]    = aq_q[aq_rd_q];
         finstr_d[fwr_q] = bus.imem_rsp_data;
         fwr_d           = fwr_q + 1'b1;
         aq_rd_d         = aq_next(aq_rd_q);
      end
      if (pop) begin
         frd_d = frd_q + 1'b1;
      end
      if (bus.flush) begin
         // every response still owed, including one arriving now, belongs to the wrong path
         drop_d     = inflight_q - IW'(rsp_ok);
         inflight_d = inflight_q - IW'(rsp_ok);
         aq_wr_d    = '0;
         aq_rd_d    = '0;
         fwr_d      = '0;
         frd_d      = '0;
         fcnt_d     = '0;
      end
   end

   // state registers, async active-low reset clears counters, queues and FIFO storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_q <= '0;
         drop_q     <= '0;
         aq_wr_q    <= '0;
         aq_rd_q    <= '0;
         fwr_q      <= '0;
         frd_q      <= '0;
         fcnt_q     <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) aq_q[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fpc_q[i]    <= '0;
            finstr_q[i] <= '0;
         end
      end else begin
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         aq_q       <= aq_d;
         aq_wr_q    <= aq_wr_d;
         aq_rd_q    <= aq_rd_d;
         fpc_q      <= fpc_d;
         finstr_q   <= finstr_d;
         fwr_q      <= fwr_d;
         frd_q      <= frd_d;
         fcnt_q     <= fcnt_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_stage_if bus ();

   fetch_stage #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        rr;
      logic        rv;
      logic [31:0] rd;
      logic        ir;
      logic        e_rv;
      logic        e_hold;
      logic        e_idv;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vec [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic [31:0] pc, input logic fl, input logic rr,
                      input logic rv, input logic [31:0] rd, input logic ir);
      bus.pc             = pc;
      bus.flush          = fl;
      bus.imem_req_ready = rr;
      bus.imem_rsp_valid = rv;
      bus.imem_rsp_data  = rd;
      bus.id_ready       = ir;
   endtask

   task automatic chk_out(input string nm, input logic rv, input logic hold, input logic idv);
      chk({nm, ".req_valid"}, 32'(bus.imem_req_valid), 32'(rv));
      chk({nm, ".pc_hold"},   32'(bus.pc_hold),        32'(hold));
      chk({nm, ".id_valid"},  32'(bus.id_valid),       32'(idv));
   endtask

   task automatic chk_id(input string nm, input logic [31:0] pc, input logic [31:0] instr);
      chk({nm, ".id_pc"},       bus.id_pc,       pc);
      chk({nm, ".id_pc_plus4"}, bus.id_pc_plus4, pc + 32'd4);
      chk({nm, ".id_instr"},    bus.id_instr,    instr);
   endtask

   // hold reset across two edges with flush and ready asserted, check reset outputs, release
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      drv(32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk_out("rst", 1'b0, 1'b1, 1'b0);
      chk("rst.id_pc",    bus.id_pc,    32'h0);
      chk("rst.id_instr", bus.id_instr, 32'h0);
      drv(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      drv(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      //          pc     fl    rr    rv    rd             ir     e_rv  hold  idv   e_pc   e_instr
      vec[0]  = '{32'h00, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0};
      vec[1]  = '{32'h04, 1'b0, 1'b1, 1'b1, 32'hC0DE0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0};
      vec[2]  = '{32'h08, 1'b0, 1'b1, 1'b1, 32'hC0DE0004, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 32'hC0DE0000};
      vec[3]  = '{32'h0C, 1'b0, 1'b1, 1'b1, 32'hC0DE0008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h04, 32'hC0DE0004};
      vec[4]  = '{32'h10, 1'b0, 1'b1, 1'b1, 32'hC0DE000C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h08, 32'hC0DE0008};
      vec[5]  = '{32'h14, 1'b0, 1'b1, 1'b1, 32'hC0DE0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[6]  = '{32'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[7]  = '{32'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[8]  = '{32'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[9]  = '{32'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[10] = '{32'h14, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'hC0DE000C};
      vec[11] = '{32'h18, 1'b0, 1'b1, 1'b1, 32'hC0DE0014, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hC0DE0010};
      vec[12] = '{32'h1C, 1'b0, 1'b1, 1'b1, 32'hC0DE0018, 1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 32'hC0DE0014};
      vec[13] = '{32'h20, 1'b0, 1'b0, 1'b1, 32'hC0DE001C, 1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 32'hC0DE0018};
      vec[14] = '{32'h20, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h1C, 32'hC0DE001C};
      vec[15] = '{32'h20, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 32'h0};

      // streaming fetch, then a 5-cycle decode stall and drain
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drv(vec[i].pc, vec[i].fl, vec[i].rr, vec[i].rv, vec[i].rd, vec[i].ir);
         #1;
         chk_out($sformatf("v%0d", i), vec[i].e_rv, vec[i].e_hold, vec[i].e_idv);
         if (vec[i].e_rv)
            chk($sformatf("v%0d.addr", i), bus.imem_req_addr, {vec[i].pc[31:2], 2'b00});
         if (vec[i].e_idv)
            chk_id($sformatf("v%0d", i), vec[i].e_pc, vec[i].e_instr);
         @(negedge clk);
      end

      // flush with two slow requests outstanding
      do_reset();
      drv(32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t3a", 1'b1, 1'b0, 1'b0);
      chk("t3a.addr", bus.imem_req_addr, 32'h10);
      @(negedge clk);
      drv(32'h14, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t3b", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t3c", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h100, 1'b0, 1'b1, 1'b1, 32'hDEAD0010, 1'b1); #1; chk_out("t3d", 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h100, 1'b0, 1'b1, 1'b1, 32'hDEAD0014, 1'b1); #1; chk_out("t3e", 1'b1, 1'b0, 1'b0);
      chk("t3e.addr", bus.imem_req_addr, 32'h100);
      @(negedge clk);
      drv(32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1; chk_out("t3f", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h104, 1'b0, 1'b0, 1'b1, 32'hC0DE0100, 1'b1); #1; chk_out("t3g", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk("t3h.id_valid", 32'(bus.id_valid), 32'h1);
      chk_id("t3h", 32'h100, 32'hC0DE0100);
      @(negedge clk);

      // flush coinciding with a response, one more still pending
      do_reset();
      drv(32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t4a", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h24, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t4b", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h200, 1'b1, 1'b1, 1'b1, 32'hDEAD0020, 1'b1); #1; chk_out("t4c", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h200, 1'b0, 1'b1, 1'b1, 32'hDEAD0024, 1'b1); #1; chk_out("t4d", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h204, 1'b0, 1'b0, 1'b1, 32'hC0DE0200, 1'b1); #1; chk_out("t4e", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h204, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk("t4f.id_valid", 32'(bus.id_valid), 32'h1);
      chk_id("t4f", 32'h200, 32'hC0DE0200);
      @(negedge clk);

      // imem backpressure, then wrap of pc+4 at the top of the address space
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
         chk_out($sformatf("t5s%0d", i), 1'b1, 1'b1, 1'b0);
         chk($sformatf("t5s%0d.addr", i), bus.imem_req_addr, 32'hFFFFFFFC);
         @(negedge clk);
      end
      drv(32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t5f", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h0, 1'b0, 1'b0, 1'b1, 32'h00000013, 1'b1); #1; chk_out("t5r", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk("t5o.id_valid", 32'(bus.id_valid), 32'h1);
      chk_id("t5o", 32'hFFFFFFFC, 32'h00000013);
      chk("t5o.plus4_wrap", bus.id_pc_plus4, 32'h0);
      @(negedge clk);

      // async reset with a full output FIFO, then clean restart
      do_reset();
      drv(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1; chk_out("t6a", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h4, 1'b0, 1'b1, 1'b1, 32'hC0DE0000, 1'b0); #1; chk_out("t6b", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drv(32'h8, 1'b0, 1'b1, 1'b1, 32'hC0DE0004, 1'b0); #1; chk_out("t6c", 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      drv(32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1; chk_out("t6d", 1'b0, 1'b1, 1'b1);
      chk_id("t6d", 32'h0, 32'hC0DE0000);
      #1;
      reset = 1'b0;
      #1;
      chk_out("t6r", 1'b0, 1'b1, 1'b0);
      chk("t6r.id_pc",    bus.id_pc,    32'h0);
      chk("t6r.id_instr", bus.id_instr, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      drv(32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1; chk_out("t6x", 1'b1, 1'b0, 1'b0);
      chk("t6x.addr", bus.imem_req_addr, 32'h0);
      @(negedge clk);
      drv(32'h4, 1'b0, 1'b0, 1'b1, 32'hC0DE1000, 1'b1); #1; chk_out("t6y", 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drv(32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk("t6z.id_valid", 32'(bus.id_valid), 32'h1);
      chk_id("t6z", 32'h0, 32'hC0DE1000);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
